mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port of the multi-cycle RISC-V core between the fetch stage (IF) and the
//  load/store stage (D). It runs one outstanding transaction at a time and drives per-requester grant/valid
//  and stall signals. It kills in-flight fetch responses on a PC redirect and bounds fetch starvation.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width; byte-enable width = DATA_W/8
//  STARVE_MAX  4   max consecutive D grants while if_req pending before IF is forced to win (>=1)
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         asynchronous, active-low reset
//  if_req      in   1         fetch request; held until if_gnt
//  if_addr     in   ADDR_W    fetch address (PCF)
//  if_flush    in   1         PC redirect; kills fetch currently owned by arbiter
//  if_gnt      out  1         fetch accepted this cycle
//  if_rvalid   out  1         fetch data valid (1-cycle pulse)
//  if_rdata    out  DATA_W    fetched instruction
//  d_req       in   1         load/store request; held until d_gnt
//  d_we        in   1         1=store
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    store data
//  d_be        in   DATA_W/8  byte enables
//  d_gnt       out  1         data request accepted this cycle
//  d_rvalid    out  1         load data valid / store ack (1-cycle pulse)
//  d_rdata     out  DATA_W    load data
//  mem_req     out  1         memory request; held until mem_ready
//  mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
//  mem_ready   in   1         memory accepted request
//  mem_rvalid  in   1         response (read data or write ack), earliest 1 cycle after mem_ready
//  mem_rdata   in   DATA_W    read data
//  stall_f     out  1         if_req & ~if_rvalid (drives StallF)
//  stall_m     out  1         d_req-or-D-owned & ~d_rvalid
//  proto_err   out  1         sticky: mem_rvalid seen outside RESP
// BEHAVIOUR
//  - Reset: state IDLE, owner NONE, kill=0, starve_cnt=0, proto_err=0; all mem_* request regs and
//    every out pulse 0. Reset mid-transaction abandons it; a later stray mem_rvalid sets proto_err only.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//    IDLE: if any req, pick winner, assert its gnt combinationally, latch fields+owner, go REQ.
//    REQ: mem_req=1 with latched fields; on mem_ready go RESP.
//    RESP: wait mem_rvalid; route to owner's rvalid/rdata combinationally (no added latency); go IDLE.
//  - Min latency req->rvalid = 3 cycles (gnt c0, mem_req+ready c1, rvalid c2); next gnt earliest c3.
//  - Priority: D wins if d_req, unless starve_cnt==STARVE_MAX and if_req, then IF wins.
//    starve_cnt: +1 on each D grant while if_req=1; cleared on IF grant or if_req=0; saturates.
//  - Flush: if_flush while owner=IF in REQ/RESP sets kill; the response completes on the bus but
//    if_rvalid is suppressed; kill clears on return to IDLE. Flush in IDLE: no effect, grant unaffected.
//    Flush in the same cycle as mem_rvalid: response suppressed.
//  - rdata outputs are valid only with their rvalid; otherwise don't-care (may mirror mem_rdata).
//  - mem_rvalid in IDLE/REQ: ignored for routing, sets proto_err.
//  - Request fields are latched only at grant; requester changes after gnt have no effect.
// STRUCTURE
//  - mem_arb_pkg: typedef enum {IDLE,REQ,RESP} arb_state_t; typedef enum {OWN_NONE,OWN_IF,OWN_D} arb_owner_t.
//  - One sub-module, mem_arb_prio: combinational winner select + starve_cnt register (STARVE_MAX param).
// TESTING
//  1. IF only, addr 0x0000_0010, mem_ready c1, rvalid c2 with 0x0051_0093 -> if_gnt c0, if_rvalid c2, rdata match, stall_f low c2.
//  2. if_req+d_req same cycle, d store 0xDEAD_BEEF be=4'hF @0x100 -> d_gnt first, mem_we=1; IF granted next IDLE.
//  3. d_req held high 6 txns, if_req high, STARVE_MAX=4 -> grants D,D,D,D,IF,D.
//  4. if_flush in RESP of IF txn -> no if_rvalid; mem side completes; next IF grant normal.
//  5. mem_ready held low 5 cycles -> mem_req/fields stable, stall_f high throughout.
//  6. rst low mid-RESP, then mem_rvalid after release -> all outputs 0, no rvalid, proto_err=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types for the unified memory-port arbiter of the multi-cycle
//   RISC-V core.
//   - arb_state_t : transaction FSM state (IDLE -> REQ -> RESP -> IDLE)
//   - arb_owner_t : which requester owns the transaction currently in flight
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  // A transaction is "in flight" from the cycle after grant until the
  // response returns; only then can a fetch be killed by a redirect.
  function automatic logic in_flight(input arb_state_t st);
    return (st == REQ) || (st == RESP);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Memory-side bus of the arbiter: one request at a time, request held
//   until ready, response (read data or write ack) on rvalid.
//   Modports:
//     master : arbiter side  (drives req/we/addr/wdata/be)
//     slave  : memory side   (drives ready/rvalid/rdata)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// ---------------------------------------------------------------------------
// mem_arb_prio
//   Winner selection between fetch (IF) and load/store (D) plus the fetch
//   starvation counter. D normally wins; once D has been granted STARVE_MAX
//   times in a row while IF was waiting, IF is forced to win.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     arb_idle   arbiter can accept a new transaction this cycle
//     if_req     fetch request pending
//     d_req      load/store request pending
//     gnt_if     fetch wins this cycle (combinational)
//     gnt_d      load/store wins this cycle (combinational)
// ---------------------------------------------------------------------------
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_idle,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_if,
  output logic gnt_d
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             if_forced;

  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    if_forced = if_req && (starve_cnt == CNT_MAX);
    if (arb_idle) begin
      if (d_req && !if_forced) begin
        gnt_d = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end
    end
  end

  // Counts consecutive D wins that happened while IF was waiting. Any cycle
  // without a fetch request, or an IF grant, restarts the count.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || gnt_if) begin
      starve_cnt <= '0;
    end else if (gnt_d && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the core's single unified memory port between instruction fetch
//   (IF) and load/store (D). One transaction outstanding at a time:
//     IDLE : pick a winner, grant it combinationally, latch its fields
//     REQ  : present the latched request until the memory accepts it
//     RESP : wait for the response and route it straight to the owner
//   A PC redirect (if_flush) during an owned fetch kills its response.
//   Ports:
//     clk, rst                  clock, asynchronous active-low reset
//     if_req/if_addr            fetch request and PC
//     if_flush                  PC redirect
//     if_gnt/if_rvalid/if_rdata fetch grant, response pulse, instruction
//     d_req/d_we/d_addr/d_wdata/d_be  load/store request
//     d_gnt/d_rvalid/d_rdata    load/store grant, response pulse, load data
//     mem                       memory bus (master side)
//     stall_f, stall_m          pipeline stall requests
//     proto_err                 sticky: response seen outside RESP
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  input  logic                 if_flush,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DATA_W-1:0]    if_rdata,

  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  input  logic [DATA_W/8-1:0]  d_be,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DATA_W-1:0]    d_rdata,

  mem_port_arbiter_if.master   mem,

  output logic                 stall_f,
  output logic                 stall_m,
  output logic                 proto_err
);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic       kill;
  logic       perr;

  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W/8-1:0]  be_q;

  logic arb_idle;
  logic gnt_if, gnt_d;
  logic resp_done;

  // Gating with rst keeps grants quiet while reset is held, even if a
  // requester is already asserting its request.
  assign arb_idle = (state == IDLE) && rst;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .arb_idle (arb_idle),
    .if_req   (if_req),
    .d_req    (d_req),
    .gnt_if   (gnt_if),
    .gnt_d    (gnt_d)
  );

  assign resp_done = (state == RESP) && mem.rvalid;

  // Next state, memory request strobe and response routing.
  always_comb begin
    state_nxt = state;
    mem.req   = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_if || gnt_d) state_nxt = REQ;
      end
      REQ: begin
        mem.req = 1'b1;
        if (mem.ready) state_nxt = RESP;
      end
      RESP: begin
        if (mem.rvalid) begin
          state_nxt = IDLE;
          // A redirect arriving with the data still kills the fetch.
          if_rvalid = (owner == OWN_IF) && !kill && !if_flush;
          d_rvalid  = (owner == OWN_D);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured only at grant, so requesters may change
  // their inputs freely once granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (gnt_d) begin
      owner   <= OWN_D;
      we_q    <= d_we;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      be_q    <= d_be;
    end else if (gnt_if) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= if_addr;
      wdata_q <= '0;
      be_q    <= '1;
    end else if (resp_done) begin
      owner   <= OWN_NONE;
    end
  end

  // The killed fetch still completes on the memory bus; only its delivery
  // to IF is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill <= 1'b0;
    end else if (resp_done) begin
      kill <= 1'b0;
    end else if (if_flush && (owner == OWN_IF) && in_flight(state)) begin
      kill <= 1'b1;
    end
  end

  // A response while nothing is awaited is a bus protocol violation,
  // e.g. the tail of a transaction abandoned by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr <= 1'b0;
    end else if (mem.rvalid && (state != RESP)) begin
      perr <= 1'b1;
    end
  end

  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.be    = be_q;

  assign if_gnt    = gnt_if;
  assign d_gnt     = gnt_d;

  // Read data is meaningful only alongside its rvalid.
  assign if_rdata  = mem.rdata;
  assign d_rdata   = mem.rdata;

  assign stall_f   = if_req & ~if_rvalid;
  assign stall_m   = (d_req | (owner == OWN_D)) & ~d_rvalid;
  assign proto_err = perr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: single fetch, D/IF collision,
//   starvation limit, flush handling, memory back-pressure and reset in the
//   middle of a transaction. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;

  logic        stall_f, stall_m, proto_err;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem       (mem_if),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Precondition: in an IDLE cycle with the caller's requests driven.
  // Runs a zero-wait transaction and checks grant and response routing.
  task automatic run_txn(input string tag, input logic exp_if,
                         input logic [31:0] rdat);
    #1;
    check({tag, ":if_gnt"}, if_gnt, exp_if);
    check({tag, ":d_gnt"},  d_gnt,  !exp_if);
    cyc();
    mem_if.ready = 1'b1;
    #1;
    check({tag, ":mem_req"}, mem_if.req, 1'b1);
    cyc();
    mem_if.ready  = 1'b0;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = rdat;
    #1;
    check({tag, ":if_rvalid"}, if_rvalid, exp_if);
    check({tag, ":d_rvalid"},  d_rvalid,  !exp_if);
    if (exp_if) check({tag, ":if_rdata"}, if_rdata, rdat);
    else        check({tag, ":d_rdata"},  d_rdata,  rdat);
    cyc();
    mem_if.rvalid = 1'b0;
  endtask

  logic exp_seq [6];

  initial begin
    rst = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_if.ready = 0; mem_if.rvalid = 0; mem_if.rdata = '0;

    // ---- reset state ----
    cyc(); cyc();
    check("rst:mem_req",   mem_if.req,  1'b0);
    check("rst:mem_addr",  mem_if.addr, 32'h0);
    check("rst:mem_we",    mem_if.we,   1'b0);
    check("rst:proto_err", proto_err,   1'b0);
    check("rst:stall_m",   stall_m,     1'b0);
    rst = 1'b1;
    cyc();

    // ---- 1: single fetch, minimum latency ----
    if_req = 1; if_addr = 32'h0000_0010;
    #1;
    check("t1:if_gnt_c0",  if_gnt,  1'b1);
    check("t1:stall_f_c0", stall_f, 1'b1);
    cyc();
    mem_if.ready = 1;
    #1;
    check("t1:mem_req_c1",  mem_if.req,  1'b1);
    check("t1:mem_addr_c1", mem_if.addr, 32'h0000_0010);
    check("t1:mem_we_c1",   mem_if.we,   1'b0);
    check("t1:if_gnt_c1",   if_gnt,      1'b0);
    cyc();
    mem_if.ready = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h0051_0093;
    #1;
    check("t1:if_rvalid_c2", if_rvalid, 1'b1);
    check("t1:if_rdata_c2",  if_rdata,  32'h0051_0093);
    check("t1:stall_f_c2",   stall_f,   1'b0);
    check("t1:d_rvalid_c2",  d_rvalid,  1'b0);
    cyc();
    mem_if.rvalid = 0; if_req = 0;
    #1;
    check("t1:mem_req_c3",   mem_if.req, 1'b0);
    check("t1:if_rvalid_c3", if_rvalid,  1'b0);
    cyc();

    // ---- 2: simultaneous requests, store wins ----
    if_req = 1; if_addr = 32'h0000_0014;
    d_req = 1; d_we = 1; d_addr = 32'h0000_0100;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    #1;
    check("t2:d_gnt",  d_gnt,  1'b1);
    check("t2:if_gnt", if_gnt, 1'b0);
    cyc();
    d_req = 0; d_we = 0; d_wdata = 32'h1234_5678;
    mem_if.ready = 1;
    #1;
    check("t2:mem_we",    mem_if.we,    1'b1);
    check("t2:mem_addr",  mem_if.addr,  32'h0000_0100);
    check("t2:mem_wdata", mem_if.wdata, 32'hDEAD_BEEF);
    check("t2:mem_be",    mem_if.be,    4'hF);
    check("t2:stall_m",   stall_m,      1'b1);
    cyc();
    mem_if.ready = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h0;
    #1;
    check("t2:d_rvalid",  d_rvalid,  1'b1);
    check("t2:if_rvalid", if_rvalid, 1'b0);
    check("t2:stall_m_r", stall_m,   1'b0);
    cyc();
    mem_if.rvalid = 0;
    run_txn("t2_if", 1'b1, 32'h0000_0013);
    if_req = 0;
    cyc();

    // ---- 3: starvation bound, D,D,D,D,IF,D ----
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_req = 1; if_addr = 32'h0000_0200;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0300;
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("t3_%0d", i), exp_seq[i], 32'h100 + 32'(i));
    end
    if_req = 0; d_req = 0;
    cyc();

    // ---- 4: flush during owned fetch, flush in IDLE, flush with rvalid ----
    if_req = 1; if_addr = 32'h0000_0020;
    #1;
    check("t4:if_gnt_a", if_gnt, 1'b1);
    cyc();
    mem_if.ready = 1;
    cyc();
    mem_if.ready = 0; if_flush = 1;
    #1;
    check("t4:if_rvalid_flush", if_rvalid, 1'b0);
    cyc();
    if_flush = 0; mem_if.rvalid = 1; mem_if.rdata = 32'hBAD0_BAD0;
    #1;
    check("t4:if_rvalid_killed", if_rvalid, 1'b0);
    check("t4:stall_f_killed",   stall_f,   1'b1);
    cyc();
    mem_if.rvalid = 0; if_flush = 1; if_addr = 32'h0000_0024;
    #1;
    check("t4:if_gnt_idle_flush", if_gnt, 1'b1);
    cyc();
    if_flush = 0; mem_if.ready = 1;
    #1;
    check("t4:mem_addr_b", mem_if.addr, 32'h0000_0024);
    cyc();
    mem_if.ready = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h0000_0517;
    #1;
    check("t4:if_rvalid_b", if_rvalid, 1'b1);
    check("t4:if_rdata_b",  if_rdata,  32'h0000_0517);
    cyc();
    mem_if.rvalid = 0;
    #1;
    check("t4:if_gnt_c", if_gnt, 1'b1);
    cyc();
    mem_if.ready = 1;
    cyc();
    mem_if.ready = 0; mem_if.rvalid = 1; if_flush = 1;
    #1;
    check("t4:if_rvalid_same", if_rvalid, 1'b0);
    cyc();
    mem_if.rvalid = 0; if_flush = 0; if_req = 0;
    #1;
    check("t4:proto_err", proto_err, 1'b0);
    cyc();

    // ---- 5: back-pressure, fields stable ----
    if_req = 1; if_addr = 32'h0000_0028;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0040;
    #1;
    check("t5:d_gnt", d_gnt, 1'b1);
    cyc();
    d_req = 0; d_addr = 32'h0000_0099; d_we = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5:mem_req_%0d", i),  mem_if.req,  1'b1);
      check($sformatf("t5:mem_addr_%0d", i), mem_if.addr, 32'h0000_0040);
      check($sformatf("t5:mem_we_%0d", i),   mem_if.we,   1'b0);
      check($sformatf("t5:stall_f_%0d", i),  stall_f,     1'b1);
      cyc();
    end
    mem_if.ready = 1;
    #1;
    check("t5:mem_req_rdy", mem_if.req, 1'b1);
    cyc();
    mem_if.ready = 0; mem_if.rvalid = 1; mem_if.rdata = 32'hCAFE_F00D;
    #1;
    check("t5:d_rvalid", d_rvalid, 1'b1);
    check("t5:d_rdata",  d_rdata,  32'hCAFE_F00D);
    check("t5:stall_f",  stall_f,  1'b1);
    cyc();
    mem_if.rvalid = 0; if_req = 0;
    cyc();

    // ---- 6: reset mid-RESP, stray response afterwards ----
    if_req = 1; if_addr = 32'h0000_0030;
    #1;
    check("t6:if_gnt", if_gnt, 1'b1);
    cyc();
    mem_if.ready = 1;
    cyc();
    mem_if.ready = 0;
    #2;
    rst = 0; if_req = 0;
    #1;
    check("t6:rst_mem_req",   mem_if.req,  1'b0);
    check("t6:rst_mem_addr",  mem_if.addr, 32'h0);
    check("t6:rst_if_rvalid", if_rvalid,   1'b0);
    check("t6:rst_if_gnt",    if_gnt,      1'b0);
    check("t6:rst_stall_f",   stall_f,     1'b0);
    cyc(); cyc();
    rst = 1;
    mem_if.rvalid = 1; mem_if.rdata = 32'h7777_7777;
    #1;
    check("t6:stray_if_rvalid", if_rvalid, 1'b0);
    check("t6:stray_d_rvalid",  d_rvalid,  1'b0);
    cyc();
    mem_if.rvalid = 0;
    #1;
    check("t6:proto_err", proto_err, 1'b1);
    cyc();
    check("t6:proto_err_sticky", proto_err, 1'b1);
    check("t6:mem_req_idle",     mem_if.req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
